verdict_capture_fsm: RTL and testbench

- Sequential stage directly upstream of the 7-segment verdict display decoder.
- On a debounced operator button press, samples the measured value MEDIDA and classifies it as accepted (AC), correctable (CO) or rejected (RE).
- Drives a registered one-hot verdict plus a display-enable for a fixed hold time, then blanks and waits for button release.
- Also keeps a saturating count of rejections.

---
 rtl/verdict_capture_fsm_if.sv | 24 ++
 rtl/verdict_capture_fsm.sv | 133 +++++++++++++
 tb/tb_verdict_capture_fsm.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/verdict_capture_fsm_if.sv
// rtl/verdict_capture_fsm_if.sv - operator button/measurement inputs and verdict outputs of the capture stage
interface verdict_capture_fsm_if #(
    parameter int W = 4
);
    logic         btn_raw;
    logic [W-1:0] medida;
    logic         entrada_ac;
    logic         entrada_co;
    logic         entrada_re;
    logic         display_en;
    logic         valid;
    logic         busy;
    logic [7:0]   cont_re;

    modport master (
        output btn_raw, medida,
        input  entrada_ac, entrada_co, entrada_re, display_en, valid, busy, cont_re
    );

    modport slave (
        input  btn_raw, medida,
        output entrada_ac, entrada_co, entrada_re, display_en, valid, busy, cont_re
    );
endinterface

// File: rtl/verdict_capture_fsm.sv
// rtl/verdict_capture_fsm.sv - debounced button capture, AC/CO/RE classification, timed verdict display
module verdict_capture_fsm #(
    parameter int W           = 4,
    parameter int LIM_INF     = 4,
    parameter int LIM_SUP     = 10,
    parameter int TOL         = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    verdict_capture_fsm_if.slave bus
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        EVAL,
        SHOW,
        WAIT_REL
    } state_t;

    state_t        state, state_n;
    logic          sync1, btn_s;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [2:0]    verdict, verdict_n;   // {ac, co, re}
    logic          disp, disp_n;
    logic          valid, valid_n;
    logic [7:0]    cont, cont_n;
    logic [2:0]    cls;
    int            m;

    // Plain integer compares keep M+TOL and LIM_SUP+TOL free of overflow.
    always_comb begin
        m = int'({1'b0, bus.medida});
        if (m >= LIM_INF && m <= LIM_SUP)
            cls = 3'b100;
        else if ((m < LIM_INF && m + TOL >= LIM_INF) || (m > LIM_SUP && m <= LIM_SUP + TOL))
            cls = 3'b010;
        else
            cls = 3'b001;
    end

    always_comb begin
        state_n   = state;
        dcnt_n    = dcnt;
        hcnt_n    = hcnt;
        verdict_n = verdict;
        disp_n    = disp;
        valid_n   = 1'b0;
        cont_n    = cont;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = DEBOUNCE;
                    dcnt_n  = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_s)
                    state_n = IDLE;
                else if (dcnt == DCNT_LAST)
                    state_n = EVAL;
                else
                    dcnt_n = dcnt + DW'(1);
            end
            EVAL: begin
                state_n   = SHOW;
                hcnt_n    = '0;
                verdict_n = cls;
                disp_n    = 1'b1;
                valid_n   = 1'b1;
                if (cls[0] && cont != 8'hFF)
                    cont_n = cont + 8'd1;
            end
            SHOW: begin
                if (hcnt == HCNT_LAST) begin
                    state_n   = WAIT_REL;
                    verdict_n = 3'b000;
                    disp_n    = 1'b0;
                end else begin
                    hcnt_n = hcnt + HW'(1);
                end
            end
            WAIT_REL: begin
                if (!btn_s)
                    state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                verdict_n = 3'b000;
                disp_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            btn_s   <= 1'b0;
            state   <= IDLE;
            dcnt    <= '0;
            hcnt    <= '0;
            verdict <= 3'b000;
            disp    <= 1'b0;
            valid   <= 1'b0;
            cont    <= 8'd0;
        end else begin
            sync1   <= bus.btn_raw;
            btn_s   <= sync1;
            state   <= state_n;
            dcnt    <= dcnt_n;
            hcnt    <= hcnt_n;
            verdict <= verdict_n;
            disp    <= disp_n;
            valid   <= valid_n;
            cont    <= cont_n;
        end
    end

    assign bus.entrada_ac = verdict[2];
    assign bus.entrada_co = verdict[1];
    assign bus.entrada_re = verdict[0];
    assign bus.display_en = disp;
    assign bus.valid      = valid;
    assign bus.busy       = (state != IDLE);
    assign bus.cont_re    = cont;
endmodule

// File: tb/tb_verdict_capture_fsm.sv
// tb/tb_verdict_capture_fsm.sv - randomized press/verdict bench for verdict_capture_fsm
module tb_verdict_capture_fsm;
    localparam int LIM_INF     = 4;
    localparam int LIM_SUP     = 10;
    localparam int TOL         = 2;
    localparam int DEB_CYCLES  = 4;
    localparam int HOLD_CYCLES = 16;
    localparam logic [2:0] V_AC = 3'b100;
    localparam logic [2:0] V_CO = 3'b010;
    localparam logic [2:0] V_RE = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_cont = 0;

    verdict_capture_fsm_if #(.W(4)) bus ();

    verdict_capture_fsm #(
        .W(4), .LIM_INF(LIM_INF), .LIM_SUP(LIM_SUP), .TOL(TOL),
        .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] classify(input int m);
        if (m >= LIM_INF && m <= LIM_SUP) return V_AC;
        if (m < LIM_INF && LIM_INF - m <= TOL) return V_CO;
        if (m > LIM_SUP && m - LIM_SUP <= TOL) return V_CO;
        return V_RE;
    endfunction

    function automatic logic [31:0] outs();
        return {25'd0, bus.entrada_ac, bus.entrada_co, bus.entrada_re,
                bus.display_en, bus.valid, bus.busy, 1'b0};
    endfunction

    // One press: button high for n sampled edges, then released until the block settles.
    task automatic press(input logic [3:0] m, input int n, input logic [2:0] exp_v, input string tag);
        int         nvalid = 0;
        int         vedge = -1;
        int         ndisp = 0;
        int         bad = 0;
        logic [2:0] vv = 3'b000;
        logic       busy_at_n = 1'b0;
        bit         recog = (n >= DEB_CYCLES + 1);
        bus.medida = m;
        for (int k = 1; k <= n + DEB_CYCLES + HOLD_CYCLES + 12; k++) begin
            @(negedge clk);
            bus.btn_raw = (k <= n);
            @(posedge clk);
            #1;
            if (bus.valid) begin
                nvalid++;
                vedge = k;
                vv = {bus.entrada_ac, bus.entrada_co, bus.entrada_re};
            end
            if (bus.display_en) begin
                ndisp++;
                if ({bus.entrada_ac, bus.entrada_co, bus.entrada_re} != vv) bad++;
            end else if ({bus.entrada_ac, bus.entrada_co, bus.entrada_re} != 3'b000) begin
                bad++;
            end
            if (k == n) busy_at_n = bus.busy;
        end
        if (recog && exp_v == V_RE && exp_cont < 255) exp_cont++;
        check({tag, ".valid_cnt"}, nvalid, recog ? 1 : 0);
        if (recog) begin
            check({tag, ".latency"}, vedge, DEB_CYCLES + 4);
            check({tag, ".verdict"}, {29'd0, vv}, {29'd0, exp_v});
        end
        check({tag, ".disp_cycles"}, ndisp, recog ? HOLD_CYCLES : 0);
        check({tag, ".stable_onehot"}, bad, 0);
        check({tag, ".busy_held"}, {31'd0, busy_at_n}, (n >= 3) ? 1 : 0);
        check({tag, ".cont_re"}, {24'd0, bus.cont_re}, exp_cont);
        check({tag, ".idle_outs"}, outs(), 0);
    endtask

    initial begin
        logic [3:0] bm [10];
        logic [2:0] bv [10];
        bm = '{4'd4, 4'd10, 4'd2, 4'd3, 4'd11, 4'd12, 4'd1, 4'd13, 4'd0, 4'd15};
        bv = '{V_AC, V_AC, V_CO, V_CO, V_CO, V_CO, V_RE, V_RE, V_RE, V_RE};

        bus.btn_raw = 1'b0;
        bus.medida  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outs", outs(), 0);
        check("reset.cont", {24'd0, bus.cont_re}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        press(4'd7, 20, V_AC, "first_ac");
        for (int i = 0; i < 10; i++)
            press(bm[i], 8, bv[i], $sformatf("bound_m%0d", bm[i]));
        press(4'd7, 3, V_AC, "glitch");
        press(4'd14, 100, V_RE, "held100");

        for (int i = 0; i < 30; i++) begin
            logic [3:0] m;
            int         n;
            m = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 40);
            press(m, n, classify(int'(m)), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of SHOW must clear everything without a clock edge.
        bus.medida = 4'd7;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.btn_raw = 1'b1;
            @(posedge clk);
        end
        #1;
        check("midshow.disp_before", {31'd0, bus.display_en}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midshow.outs", outs(), 0);
        check("midshow.cont", {24'd0, bus.cont_re}, 0);
        exp_cont = 0;
        bus.btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        press(4'd7, 8, V_AC, "post_reset");

        for (int i = 0; i < 260; i++)
            press(4'd15, 6, V_RE, $sformatf("sat%0d", i));
        check("sat.final", {24'd0, bus.cont_re}, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
